// File: rtl/flight_event_sequencer_pkg.sv
// Shared flight-phase encodings, event field widths and altitude/velocity scale
// constants used by the sequencer and the upstream gimbal/altitude stages.
package flight_event_sequencer_pkg;

  localparam int PHASE_W = 3;
  localparam int TIME_W  = 32;
  localparam int EVT_W   = PHASE_W + TIME_W;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE     = 3'd0,
    PH_IGNITION = 3'd1,
    PH_ASCENT   = 3'd2,
    PH_GIMBAL   = 3'd3,
    PH_MECO     = 3'd4,
    PH_COAST    = 3'd5,
    PH_ABORT    = 3'd6
  } phase_t;

  // Height LSB is 1e-12 km, velocity LSB is 1e-9 km/s.
  localparam logic [63:0] HEIGHT_LSB_PER_KM     = 64'd1_000_000_000_000;
  localparam logic [63:0] VELOCITY_LSB_PER_KMPS = 64'd1_000_000_000;
  localparam logic [63:0] ALT_30KM_HEIGHT       = 64'd30_000_000_000_000;

  function automatic logic engine_lit(input phase_t p);
    return (p == PH_IGNITION) || (p == PH_ASCENT) || (p == PH_GIMBAL);
  endfunction

endpackage

// File: rtl/flight_event_sequencer_event_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag; the output
// holds the last popped entry while the FIFO is empty.
module event_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] last_q;
  logic         overflow_q;
  logic         empty, full, pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && ready;
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);

  assign valid    = !empty;
  assign dout     = empty ? last_q : mem[rd_q[AW-1:0]];
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_q       <= '0;
      rd_q       <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem[rd_q[AW-1:0]];
      end
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/flight_event_sequencer.sv
// Ascent phase machine with mission-elapsed seconds and a timestamped
// phase-change event queue for telemetry.
module flight_event_sequencer
  import flight_event_sequencer_pkg::*;
#(
  parameter int             N           = 64,
  parameter int             TICK_CYCLES = 50,
  parameter int             IGN_TICKS   = 3,
  parameter logic [N-1:0]   ALT_30KM    = N'(ALT_30KM_HEIGHT),
  parameter int             FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] height,
  input  logic [N-1:0] velocity,
  input  logic         gimbal_enable,
  input  logic [N-1:0] burntime,
  output logic [2:0]   phase,
  output logic [31:0]  elapsed_s,
  output logic         engine_on,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [2:0]   evt_code,
  output logic [31:0]  evt_time,
  output logic         evt_overflow
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int CW = (N > TIME_W) ? N + 1 : TIME_W + 1;

  phase_t             phase_q, phase_d;
  logic [TIME_W-1:0]  elapsed_q, elapsed_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [N-1:0]       burn_q;
  logic               engine_q;
  logic               running, tick, launch, push;
  logic [CW-1:0]      elapsed_p1;
  logic [EVT_W-1:0]   evt_head;
  logic               unused_velocity;

  assign unused_velocity = ^velocity;

  assign launch     = (phase_q == PH_IDLE) && start;
  assign running    = (phase_q != PH_IDLE) && (phase_q != PH_ABORT);
  assign tick       = running && (presc_q == PW'(TICK_CYCLES - 1));
  assign elapsed_p1 = CW'(elapsed_q) + CW'(1);

  always_comb begin
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    if (launch) begin
      presc_d   = '0;
      elapsed_d = '0;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && (elapsed_q != '1)) elapsed_d = elapsed_q + 32'd1;
    end
  end

  // One transition per cycle, highest priority first.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:  if (start) phase_d = PH_IGNITION;
      PH_ABORT: phase_d = PH_ABORT;
      default: begin
        if (abort)
          phase_d = PH_ABORT;
        else if ((phase_q == PH_ASCENT || phase_q == PH_GIMBAL) && tick &&
                 (elapsed_p1 >= CW'(burn_q)))
          phase_d = PH_MECO;
        else if (phase_q == PH_ASCENT && (gimbal_enable || height >= ALT_30KM))
          phase_d = PH_GIMBAL;
        else if (phase_q == PH_IGNITION && tick && (elapsed_p1 == CW'(IGN_TICKS)))
          phase_d = PH_ASCENT;
        else if (phase_q == PH_MECO)
          phase_d = PH_COAST;
      end
    endcase
  end

  assign push = (phase_d != phase_q);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phase_q   <= PH_IDLE;
      elapsed_q <= '0;
      presc_q   <= '0;
      burn_q    <= '0;
      engine_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      elapsed_q <= elapsed_d;
      presc_q   <= presc_d;
      engine_q  <= engine_lit(phase_d);
      if (launch) burn_q <= burntime;
    end
  end

  event_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk      (clk),
    .resetb   (resetb),
    .push     (push),
    .din      ({phase_d, elapsed_d}),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .dout     (evt_head),
    .overflow (evt_overflow)
  );

  assign phase     = phase_q;
  assign elapsed_s = elapsed_q;
  assign engine_on = engine_q;
  assign evt_code  = evt_head[EVT_W-1:TIME_W];
  assign evt_time  = evt_head[TIME_W-1:0];

endmodule

// File: doc/flight_event_sequencer.md
Name: flight_event_sequencer

Overview:
- Downstream of the altitude/gimbal path. Consumes integrated height, velocity and the gimbal-enable flag, and runs the ascent phase machine: ignition, ascent, gimbal, MECO, coast, abort.
- Keeps mission-elapsed seconds from a clock prescaler.
- Pushes timestamped phase-change events into a small FIFO, drained by a valid/ready consumer (telemetry/display).

Parameters:
- N, 64, datapath width of height/velocity/burntime
- TICK_CYCLES, 50, clk cycles per simulated second (must be >= 2)
- IGN_TICKS, 3, seconds held in IGNITION before ASCENT
- ALT_30KM, 30_000_000_000_000, gimbal altitude threshold in height LSBs (1 LSB = 1e-12 km)
- FIFO_DEPTH, 4, event FIFO entries (power of two)

Ports:
- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- start  in  1  launch command, sampled in IDLE
- abort  in  1  abort request, level, any non-IDLE phase
- height  in  N  integrated altitude, unsigned, 1e-12 km LSB
- velocity  in  N  unsigned, 1e-9 km/s LSB
- gimbal_enable  in  1  gimbal stage flag
- burntime  in  N  burn duration in seconds; sampled at start
- phase  out  3  0 IDLE, 1 IGNITION, 2 ASCENT, 3 GIMBAL, 4 MECO, 5 COAST, 6 ABORT
- elapsed_s  out  32  seconds since start
- engine_on  out  1  high in IGNITION/ASCENT/GIMBAL
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head entry
- evt_code  out  3  phase entered (same encoding as phase)
- evt_time  out  32  elapsed_s at the transition
- evt_overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset (async, resetb=0) sets all state: phase=IDLE, elapsed_s=0, prescaler=0, engine_on=0, FIFO empty, evt_valid=0, evt_code=0, evt_time=0, evt_overflow=0. Reset mid-flight discards queued events.
- Prescaler runs only when phase is not IDLE or ABORT. Counts 0..TICK_CYCLES-1. tick=1 for one cycle at TICK_CYCLES-1, then wraps. elapsed_s increments on tick and saturates at 0xFFFFFFFF.
- IDLE: start=1 -> IGNITION next cycle; latch burntime; clear elapsed_s and prescaler.
- IGNITION -> ASCENT on the tick where elapsed_s+1 == IGN_TICKS.
- ASCENT -> GIMBAL when gimbal_enable=1 or height >= ALT_30KM. Unsigned compare; evaluated every cycle.
- ASCENT or GIMBAL -> MECO on the tick where elapsed_s+1 >= burntime_latched.
- MECO -> COAST after exactly 1 cycle.
- COAST holds until reset.
- Any phase except IDLE and ABORT -> ABORT when abort=1. ABORT holds until reset; elapsed_s frozen.
- Priority within one cycle: abort > MECO > GIMBAL > IGNITION->ASCENT. Only one transition per cycle; a GIMBAL condition coinciding with MECO is dropped and produces no GIMBAL event.
- burntime_latched == 0: MECO on the first tick after reaching ASCENT. IGNITION is not cut short.
- engine_on is registered with phase (same cycle).
- Every transition pushes {code = new phase, time = elapsed_s value written in that cycle} in the same cycle as the phase register update.
- Push when full: entry dropped; evt_overflow set and held until reset.
- FIFO is first-word-fall-through: evt_code/evt_time show the head while evt_valid=1, and hold their last value when empty.
- Pop when evt_valid & evt_ready. Simultaneous push and pop when full: both succeed, no overflow.
- Latency: transition visible on evt_valid one cycle after the triggering input sample, if the FIFO was empty.

Decomposition:
- Shared package: phase encodings (PH_IDLE..PH_ABORT), phase width 3, time width 32, and the ALT_30KM and height/velocity LSB scale constants, reused by the gimbal and altitude stages.
- One sub-module: event_fifo (parameterised width 35, depth FIFO_DEPTH; FWFT; full/empty from pointers with an extra wrap bit).

Test Plan:
- Nominal (TICK_CYCLES=4, IGN_TICKS=3, burntime=10, evt_ready=1): start; height crosses ALT_30KM at second 5 -> events {1,0},{2,3},{3,5},{4,10},{5,10}; phase ends at 5; engine_on=0 from MECO.
- gimbal_enable=1 at second 4, height below threshold -> GIMBAL event time 4. gimbal_enable asserted on the same cycle as the burnout tick -> only MECO then COAST; no code 3.
- Abort at second 6 in ASCENT -> event {6,6}; elapsed_s frozen at 6; later start/gimbal_enable ignored.
- Backpressure: evt_ready=0 for the whole nominal run with FIFO_DEPTH=4 -> 4 entries held, 5th dropped, evt_overflow=1; after releasing evt_ready, codes 1,2,3,4 drain in order.
- Reset mid-GIMBAL with 2 queued events -> next cycle phase=0, evt_valid=0, elapsed_s=0, evt_overflow=0; a fresh start runs nominally.
- burntime=0 -> IGNITION lasts 3 s, then MECO at time 4, COAST at time 4.
